// File: rtl/spi_reader_pkg.sv
// Shared types and constants for the SPI burst reader: FSM state encoding,
// read-command construction and frame geometry.
package spi_reader_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CS_SETUP   = 3'd1,
    SHIFT_CMD  = 3'd2,
    SHIFT_DATA = 3'd3,
    CS_HOLD    = 3'd4,
    FINISH     = 3'd5
  } state_t;

  localparam logic       READ_FLAG          = 1'b1;
  localparam logic [4:0] DEFAULT_FIRST_ADDR = 5'd3;
  localparam int         FRAME_DATA_BYTES   = 5;

  function automatic logic [7:0] read_cmd(input logic [6:0] reg_addr);
    return {READ_FLAG, reg_addr};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: toggles sclk every CLK_DIV clk cycles while
// enabled and flags the clk edges on which sclk rises and falls.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_r;
  logic       edge_s;

  assign edge_s   = en && (cnt_r == DIV_LAST);
  assign rise_stb = edge_s && !sclk;
  assign fall_stb = edge_s && sclk;

  // half-period counter and sclk register, parked low when disabled
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      cnt_r <= 8'd0;
      sclk  <= 1'b0;
    end else if (edge_s) begin
      cnt_r <= 8'd0;
      sclk  <= ~sclk;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/spi_burst_reader.sv
// SPI master sequencer: selects a device, sends a read command for spi_reg
// and streams N_BYTES received bytes to the receive buffer with addresses.
module spi_burst_reader
  import spi_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned N_BYTES    = FRAME_DATA_BYTES,
  parameter logic [4:0]  FIRST_ADDR = DEFAULT_FIRST_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] spi_reg,
  input  logic [7:0] spi_select,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] cs_n,
  output logic [7:0] data_rec_out,
  output logic [4:0] addr_out,
  output logic       buffer_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [2:0] BYTE_LAST = 3'(N_BYTES - 1);

  state_t     state_r, state_nx_s;
  logic [7:0] wait_cnt_r, sel_r, tx_r, cs_n_nx_s;
  logic [6:0] rx_r;
  logic [2:0] bit_cnt_r, byte_cnt_r;
  logic       sclk_en_s, rise_stb_s, fall_stb_s, accept_s, reject_s;
  logic       wait_done_s, bit_last_s, byte_last_s;
  logic       busy_nx_s, done_nx_s, err_nx_s;
  logic       unused_reg_msb_s;

  // bit 7 of the command is always the read flag, so spi_reg[7] is dropped
  assign unused_reg_msb_s = spi_reg[7];

  assign sclk_en_s   = (state_r == SHIFT_CMD) || (state_r == SHIFT_DATA);
  assign accept_s    = (state_r == IDLE) && start && (spi_select != 8'h00);
  assign reject_s    = (state_r == IDLE) && start && (spi_select == 8'h00);
  assign wait_done_s = (wait_cnt_r == DIV_LAST);
  assign bit_last_s  = (bit_cnt_r == 3'd7);
  assign byte_last_s = (byte_cnt_r == BYTE_LAST);
  assign mosi        = tx_r[7];

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (sclk_en_s),
    .sclk     (sclk),
    .rise_stb (rise_stb_s),
    .fall_stb (fall_stb_s)
  );

  // next-state and next-output decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:       if (accept_s) state_nx_s = CS_SETUP; else state_nx_s = IDLE;
      CS_SETUP:   if (wait_done_s) state_nx_s = SHIFT_CMD; else state_nx_s = CS_SETUP;
      SHIFT_CMD:  if (fall_stb_s && bit_last_s) state_nx_s = SHIFT_DATA; else state_nx_s = SHIFT_CMD;
      SHIFT_DATA: if (fall_stb_s && bit_last_s && byte_last_s) state_nx_s = CS_HOLD;
                  else state_nx_s = SHIFT_DATA;
      CS_HOLD:    if (wait_done_s) state_nx_s = FINISH; else state_nx_s = CS_HOLD;
      FINISH:     state_nx_s = IDLE;
      default:    state_nx_s = IDLE;
    endcase
    busy_nx_s = (state_nx_s != IDLE);
    done_nx_s = (state_nx_s == FINISH) || reject_s;
    err_nx_s  = reject_s;
    if ((state_nx_s == IDLE) || (state_nx_s == FINISH)) begin
      cs_n_nx_s = 8'hFF;
    end else if (accept_s) begin
      cs_n_nx_s = ~spi_select;
    end else begin
      cs_n_nx_s = ~sel_r;
    end
  end

  // state, registered outputs and shift datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      cs_n         <= 8'hFF;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      buffer_en    <= 1'b0;
      data_rec_out <= 8'h00;
      addr_out     <= 5'd0;
      wait_cnt_r   <= 8'd0;
      sel_r        <= 8'h00;
      tx_r         <= 8'h00;
      rx_r         <= 7'd0;
      bit_cnt_r    <= 3'd0;
      byte_cnt_r   <= 3'd0;
    end else begin
      state_r   <= state_nx_s;
      cs_n      <= cs_n_nx_s;
      busy      <= busy_nx_s;
      done      <= done_nx_s;
      err       <= err_nx_s;
      buffer_en <= 1'b0;
      if (((state_r == CS_SETUP) || (state_r == CS_HOLD)) && (state_nx_s == state_r)) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
      end
      if (accept_s) begin
        sel_r      <= spi_select;
        tx_r       <= read_cmd(spi_reg[6:0]);
        bit_cnt_r  <= 3'd0;
        byte_cnt_r <= 3'd0;
      end
      if ((state_r == SHIFT_CMD) && fall_stb_s) begin
        tx_r <= {tx_r[6:0], 1'b0};
      end
      // a byte is complete on its 8th rising sclk; bit_cnt advances on falls
      if ((state_r == SHIFT_DATA) && rise_stb_s) begin
        rx_r <= {rx_r[5:0], miso};
        if (bit_last_s) begin
          buffer_en    <= 1'b1;
          data_rec_out <= {rx_r, miso};
          addr_out     <= FIRST_ADDR + {2'b00, byte_cnt_r};
        end
      end
      if (sclk_en_s && fall_stb_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if ((state_r == SHIFT_DATA) && bit_last_s) begin
          byte_cnt_r <= byte_cnt_r + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_reader.sv
// Directed bench for spi_burst_reader: default build with an SPI slave model
// and a CLK_DIV=1 build fed with all-ones MISO.
module tb_spi_burst_reader;

  logic       clk = 1'b0, rst = 1'b0;
  logic       start = 1'b0, miso = 1'b0;
  logic [7:0] spi_reg = 8'h00, spi_select = 8'h00;
  logic       sclk, mosi, buffer_en, busy, done, err;
  logic [7:0] cs_n, data_rec_out;
  logic [4:0] addr_out;

  logic       start1 = 1'b0, miso1 = 1'b1;
  logic [7:0] spi_reg1 = 8'h00, spi_select1 = 8'h00;
  logic       sclk1, mosi1, buffer_en1, busy1, done1, err1;
  logic [7:0] cs_n1, data_rec_out1;
  logic [4:0] addr_out1;

  int n_run = 0, n_fail = 0;
  int cyc = 0, done_cnt0 = 0, done_cnt1 = 0, sclk_rises = 0, rx_cnt = 0;
  logic [12:0] q0[$], q1[$];
  logic [7:0]  miso_bytes[5];
  logic [7:0]  cmd_cap = 8'h00;

  spi_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .spi_reg(spi_reg), .spi_select(spi_select),
    .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .data_rec_out(data_rec_out),
    .addr_out(addr_out), .buffer_en(buffer_en), .busy(busy), .done(done), .err(err)
  );

  spi_burst_reader #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .spi_reg(spi_reg1), .spi_select(spi_select1),
    .miso(miso1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .data_rec_out(data_rec_out1),
    .addr_out(addr_out1), .buffer_en(buffer_en1), .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge sclk) sclk_rises <= sclk_rises + 1;

  // strobe and done logger, sampled mid-cycle
  always @(negedge clk) begin
    if (buffer_en) q0.push_back({addr_out, data_rec_out});
    if (buffer_en1) q1.push_back({addr_out1, data_rec_out1});
    if (done) done_cnt0 <= done_cnt0 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  // mode-0 slave: capture command on rises, present next data bit on falls
  always @(sclk or cs_n) begin
    if (cs_n == 8'hFF) begin
      rx_cnt = 0;
      miso = 1'b0;
    end else if (sclk) begin
      if (rx_cnt < 8) cmd_cap = {cmd_cap[6:0], mosi};
      rx_cnt = rx_cnt + 1;
    end else if ((rx_cnt >= 8) && (rx_cnt < 48)) begin
      miso = miso_bytes[(rx_cnt - 8) / 8][7 - ((rx_cnt - 8) % 8)];
    end else begin
      miso = 1'b0;
    end
  end

  task automatic run_txn(input logic [7:0] reg_v, input logic [7:0] sel_v,
                         output int lat, output int cs_bad);
    int t0;
    @(negedge clk);
    spi_reg = reg_v; spi_select = sel_v; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0; lat = -1; cs_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin lat = cyc - t0; break; end
      if (cs_n !== ~sel_v) cs_bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_run++;
    if ({sclk, mosi, cs_n, data_rec_out, addr_out, buffer_en, busy, done, err} !== {2'b00, 8'hFF, 8'h00, 5'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got sclk=%b mosi=%b cs_n=%h data=%h addr=%0d be=%b busy=%b done=%b err=%b, want 0 0 ff 00 0 0 0 0 0",
               sclk, mosi, cs_n, data_rec_out, addr_out, buffer_en, busy, done, err);
    end
    n_run++;
    if ({sclk1, cs_n1, buffer_en1, busy1, done1} !== {1'b0, 8'hFF, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_div1: got sclk=%b cs_n=%h be=%b busy=%b done=%b, want 0 ff 0 0 0", sclk1, cs_n1, buffer_en1, busy1, done1);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, cs_bad, base, d0;
    logic [12:0] got;
    logic [7:0] exp_b[5] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81};
    miso_bytes = exp_b; base = q0.size(); d0 = done_cnt0;
    run_txn(8'h12, 8'h04, lat, cs_bad);
    n_run++;
    if (lat !== 393) begin n_fail++; $display("FAIL basic_latency: got %0d cycles, want 393", lat); end
    n_run++;
    if (cs_bad !== 0) begin n_fail++; $display("FAIL basic_cs_n: %0d cycles not fb, want 0", cs_bad); end
    n_run++;
    if (cmd_cap !== 8'h92) begin n_fail++; $display("FAIL basic_cmd: got %h, want 92", cmd_cap); end
    n_run++;
    if ({cs_n, busy, err} !== {8'hFF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL basic_finish: got cs_n=%h busy=%b err=%b, want ff 1 0", cs_n, busy, err);
    end
    @(negedge clk);
    n_run++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL basic_after_done: got busy=%b done=%b, want 0 0", busy, done); end
    n_run++;
    if ((q0.size() - base !== 5) || (done_cnt0 - d0 !== 1)) begin
      n_fail++; $display("FAIL basic_counts: got %0d strobes %0d done, want 5 1", q0.size() - base, done_cnt0 - d0);
    end
    for (int k = 0; k < 5; k++) begin
      got = (base + k < q0.size()) ? q0[base + k] : 13'h1FFF;
      n_run++;
      if (got !== {5'(3 + k), exp_b[k]}) begin
        n_fail++; $display("FAIL basic_strobe%0d: got addr=%0d data=%h, want addr=%0d data=%h", k, got[12:8], got[7:0], 3 + k, exp_b[k]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int base, d0, cs_bad = 0;
    logic [7:0] exp_b[5] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'h7E};
    miso_bytes = exp_b; base = q0.size(); d0 = done_cnt0;
    @(negedge clk);
    spi_reg = 8'h34; spi_select = 8'h02; start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) break;
      if (cs_n !== 8'hFD) cs_bad++;
      spi_select = (i % 2 == 0) ? 8'h01 : 8'(8'h01 << (i % 8));
      spi_reg = 8'(i);
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_run++;
    if (cs_bad !== 0) begin n_fail++; $display("FAIL ignore_cs_n: %0d cycles not fd, want 0", cs_bad); end
    n_run++;
    if (cmd_cap !== 8'hB4) begin n_fail++; $display("FAIL ignore_cmd: got %h, want b4", cmd_cap); end
    n_run++;
    if ((q0.size() - base !== 5) || (done_cnt0 - d0 !== 1)) begin
      n_fail++; $display("FAIL ignore_counts: got %0d strobes %0d done, want 5 1", q0.size() - base, done_cnt0 - d0);
    end
    n_run++;
    if ({busy, cs_n} !== {1'b0, 8'hFF}) begin n_fail++; $display("FAIL ignore_idle: got busy=%b cs_n=%h, want 0 ff", busy, cs_n); end
    n_run++;
    if ((q0.size() >= base + 5) && (q0[base + 4] !== {5'd7, 8'h7E})) begin
      n_fail++; $display("FAIL ignore_last_strobe: got %h, want %h", q0[base + 4], {5'd7, 8'h7E});
    end
  endtask

  task automatic test_zero_select();
    int r0 = sclk_rises;
    @(negedge clk);
    spi_reg = 8'h12; spi_select = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_run++;
    if ({done, err, busy, cs_n, sclk} !== {3'b110, 8'hFF, 1'b0}) begin
      n_fail++; $display("FAIL zero_sel_pulse: got done=%b err=%b busy=%b cs_n=%h sclk=%b, want 1 1 0 ff 0", done, err, busy, cs_n, sclk);
    end
    repeat (20) @(negedge clk);
    n_run++;
    if ({done, err, busy, cs_n} !== {3'b000, 8'hFF} || sclk_rises !== r0) begin
      n_fail++; $display("FAIL zero_sel_after: got done=%b err=%b busy=%b cs_n=%h rises=%0d, want 0 0 0 ff %0d", done, err, busy, cs_n, sclk_rises, r0);
    end
  endtask

  task automatic test_mid_reset();
    int base, d0, lat, cs_bad;
    logic [12:0] got;
    logic [7:0] exp_b[5] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h42};
    miso_bytes = exp_b; base = q0.size(); d0 = done_cnt0;
    @(negedge clk);
    spi_reg = 8'h21; spi_select = 8'h08; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (q0.size() - base >= 2) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if ({sclk, mosi, cs_n, data_rec_out, addr_out, buffer_en, busy, done, err} !== {2'b00, 8'hFF, 8'h00, 5'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL midrst_outputs: got sclk=%b mosi=%b cs_n=%h data=%h addr=%0d be=%b busy=%b done=%b err=%b, want 0 0 ff 00 0 0 0 0 0",
               sclk, mosi, cs_n, data_rec_out, addr_out, buffer_en, busy, done, err);
    end
    rst = 1'b1;
    repeat (600) @(negedge clk);
    n_run++;
    if ((q0.size() - base !== 2) || (done_cnt0 !== d0)) begin
      n_fail++; $display("FAIL midrst_aborted: got %0d strobes %0d done, want 2 0", q0.size() - base, done_cnt0 - d0);
    end
    run_txn(8'h05, 8'h40, lat, cs_bad);
    @(negedge clk);
    n_run++;
    if ((lat !== 393) || (cs_bad !== 0) || (cmd_cap !== 8'h85)) begin
      n_fail++; $display("FAIL midrst_next_txn: got lat=%0d cs_bad=%0d cmd=%h, want 393 0 85", lat, cs_bad, cmd_cap);
    end
    for (int k = 0; k < 5; k++) begin
      got = (base + 2 + k < q0.size()) ? q0[base + 2 + k] : 13'h1FFF;
      n_run++;
      if (got !== {5'(3 + k), exp_b[k]}) begin
        n_fail++; $display("FAIL midrst_strobe%0d: got addr=%0d data=%h, want addr=%0d data=%h", k, got[12:8], got[7:0], 3 + k, exp_b[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, d0, lat_a, lat_b, bad_a, bad_b;
    logic [12:0] got, exp_v;
    logic [7:0] bytes_a[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] bytes_b[5] = '{8'h66, 8'h77, 8'h88, 8'h99, 8'hC3};
    miso_bytes = bytes_a; base = q0.size(); d0 = done_cnt0;
    run_txn(8'h0A, 8'h10, lat_a, bad_a);
    n_run++;
    if (cs_n !== 8'hFF) begin n_fail++; $display("FAIL b2b_gap_cs_n: got %h at done, want ff", cs_n); end
    miso_bytes = bytes_b;
    run_txn(8'h7B, 8'h20, lat_b, bad_b);
    @(negedge clk);
    n_run++;
    if ((lat_a !== 393) || (lat_b !== 393) || (bad_a !== 0) || (bad_b !== 0)) begin
      n_fail++; $display("FAIL b2b_timing: got lat %0d/%0d cs_bad %0d/%0d, want 393/393 0/0", lat_a, lat_b, bad_a, bad_b);
    end
    n_run++;
    if ((q0.size() - base !== 10) || (done_cnt0 - d0 !== 2) || (cmd_cap !== 8'hFB)) begin
      n_fail++; $display("FAIL b2b_counts: got %0d strobes %0d done cmd=%h, want 10 2 fb", q0.size() - base, done_cnt0 - d0, cmd_cap);
    end
    for (int k = 0; k < 10; k++) begin
      got = (base + k < q0.size()) ? q0[base + k] : 13'h1FFF;
      exp_v = {5'(3 + (k % 5)), (k < 5) ? bytes_a[k % 5] : bytes_b[k % 5]};
      n_run++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL b2b_strobe%0d: got %h, want %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_clkdiv1();
    int t0, lat = -1, base = q1.size();
    @(negedge clk);
    spi_reg1 = 8'h7F; spi_select1 = 8'h01; start1 = 1'b1; t0 = cyc;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (done1) begin lat = cyc - t0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    n_run++;
    if ((lat !== 99) || (q1.size() - base !== 5)) begin
      n_fail++; $display("FAIL div1_latency: got lat=%0d strobes=%0d, want 99 5", lat, q1.size() - base);
    end
    for (int k = 0; k < 5; k++) begin
      n_run++;
      if ((base + k >= q1.size()) || (q1[base + k] !== {5'(3 + k), 8'hFF})) begin
        n_fail++; $display("FAIL div1_strobe%0d: got %h, want %h", k, (base + k < q1.size()) ? q1[base + k] : 13'h1FFF, {5'(3 + k), 8'hFF});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_zero_select();
    test_mid_reset();
    test_back_to_back();
    test_clkdiv1();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
